// File: rtl/ninjakun_spchr_fetch_if.sv
// Byte-wide handshaked ROM read port used by the sprite CHR fetch unit.
// The fetch unit is the master; the shared ROM arbiter is the slave.
interface ninjakun_spchr_fetch_if;
  logic [15:0] ROMAD;
  logic        ROMRQ;
  logic [7:0]  ROMDT;
  logic        ROMAK;

  modport master (output ROMAD, ROMRQ, input ROMDT, ROMAK);
  modport slave  (input ROMAD, ROMRQ, output ROMDT, ROMAK);
endinterface

// File: rtl/ninjakun_spchr_fetch.sv
// Sprite CHR row fetch: reads four ROM bytes per 13-bit row address and
// presents the 32-bit row with a one-cycle strobe, with a one-entry row cache.
module ninjakun_spchr_fetch #(
  parameter logic [15:0] ROM_BASE = 16'h0000,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic                   VCLKx4,
  input  logic                   RESET,
  input  logic [12:0]            SPCAD,
  output logic [31:0]            SPCDT,
  output logic                   SPCFT,
  ninjakun_spchr_fetch_if.master rom
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, HIT} state_t;

  state_t      state, state_d;
  logic [12:0] areg;
  logic [12:0] tag;
  logic        valid;
  logic [1:0]  bix;
  logic [23:0] asm_q;
  logic        hit;
  logic        ack;

  assign hit       = CACHE_EN && valid && (SPCAD == tag);
  assign ack       = (state == REQ) && rom.ROMAK;
  assign rom.ROMAD = ROM_BASE + {1'b0, areg, bix};

  always_comb begin
    state_d   = state;
    rom.ROMRQ = 1'b0;
    SPCFT     = 1'b0;
    case (state)
      IDLE: state_d = hit ? HIT : REQ;
      REQ: begin
        rom.ROMRQ = 1'b1;
        if (ack && (bix == 2'd3)) state_d = DONE;
      end
      DONE: begin
        SPCFT   = 1'b1;
        state_d = IDLE;
      end
      HIT: begin
        SPCFT   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge VCLKx4 or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  // Row, tag and valid load on the final ack so they are already valid while
  // SPCFT is high in DONE. SPCDT doubles as the cached row: it only ever
  // changes together with the tag, so a hit just re-strobes it.
  always_ff @(posedge VCLKx4 or posedge RESET) begin
    if (RESET) begin
      areg  <= '0;
      bix   <= '0;
      asm_q <= '0;
      SPCDT <= '0;
      tag   <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          areg <= SPCAD;
          bix  <= '0;
        end
        REQ: begin
          if (ack) begin
            if (bix == 2'd3) begin
              SPCDT <= {rom.ROMDT, asm_q};
              tag   <= areg;
              valid <= 1'b1;
            end else begin
              asm_q[{bix, 3'b000} +: 8] <= rom.ROMDT;
              bix                       <= bix + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ninjakun_spchr_fetch.sv
// Scoreboard bench for ninjakun_spchr_fetch: three instances (cached, uncached,
// wrapping base) each with a small ROM model; stimulus queues expectations.
module tb_ninjakun_spchr_fetch;

  localparam logic [15:0] BASES [3] = '{16'h0000, 16'h0000, 16'hFFFE};
  localparam bit          CEN   [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic [7:0]  gap;
    logic [31:0] d;
  } exp_t;

  logic VCLKx4 = 1'b0;
  always #5 VCLKx4 = ~VCLKx4;

  logic        rst   [3] = '{1'b1, 1'b1, 1'b1};
  logic [12:0] spcad [3] = '{13'h0, 13'h0, 13'h0};
  int unsigned stall_cycles [3] = '{0, 0, 0};

  wire [31:0] dt [3];
  wire        ft [3];
  wire        rq [3];
  wire        ak [3];
  wire [15:0] ad [3];

  logic [15:0] qad [3][$];
  exp_t        qrw [3][$];

  int n_pass   = 0;
  int n_total  = 0;
  int timeouts = 0;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h0014: return 8'h11;
      16'h0015: return 8'h22;
      16'h0016: return 8'h33;
      16'h0017: return 8'h44;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ninjakun_spchr_fetch_if rif ();
    logic [1:0]  ack_idx;
    int unsigned stall_cnt;

    ninjakun_spchr_fetch #(.ROM_BASE(BASES[g]), .CACHE_EN(CEN[g])) u_dut (
      .VCLKx4 (VCLKx4),
      .RESET  (rst[g]),
      .SPCAD  (spcad[g]),
      .SPCDT  (dt[g]),
      .SPCFT  (ft[g]),
      .rom    (rif)
    );

    // ROM model: optional wait states on the third byte of a fetch.
    assign rif.ROMDT = rom_byte(rif.ROMAD);
    assign rif.ROMAK = rif.ROMRQ && !(ack_idx == 2'd2 && stall_cnt < stall_cycles[g]);

    always @(posedge VCLKx4 or posedge rst[g]) begin
      if (rst[g]) begin
        ack_idx   <= '0;
        stall_cnt <= 0;
      end else if (rif.ROMRQ && rif.ROMAK) begin
        ack_idx   <= ack_idx + 2'd1;
        stall_cnt <= 0;
      end else if (rif.ROMRQ) begin
        stall_cnt <= stall_cnt + 1;
      end
    end

    assign ad[g] = rif.ROMAD;
    assign rq[g] = rif.ROMRQ;
    assign ak[g] = rif.ROMAK;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[u%0d] got %h want %h at %0t", nm, i, act, exp, $time);
  endtask

  logic        prev_rst [3] = '{1'b0, 1'b0, 1'b0};
  int unsigned cnt      [3];
  logic [31:0] last     [3];

  always begin
    exp_t e;
    @(negedge VCLKx4 or posedge rst[0] or posedge rst[1] or posedge rst[2]);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        if (!prev_rst[i]) begin
          qad[i].delete();
          qrw[i].delete();
        end
        chk("rst_spcdt", i, dt[i], 32'd0);
        chk("rst_spcft", i, 32'(ft[i]), 32'd0);
        chk("rst_romrq", i, 32'(rq[i]), 32'd0);
        chk("rst_romad", i, 32'(ad[i]), 32'(BASES[i]));
        cnt[i]  = 0;
        last[i] = '0;
      end else if (!VCLKx4) begin
        cnt[i]++;
        if (rq[i]) begin
          chk("req_expected", i, 32'(qad[i].size() != 0), 32'd1);
          if (qad[i].size() != 0) begin
            if (ak[i]) chk("romad", i, 32'(ad[i]), 32'(qad[i].pop_front()));
            else       chk("romad_wait", i, 32'(ad[i]), 32'(qad[i][0]));
          end
        end
        if (ft[i]) begin
          chk("strobe_expected", i, 32'(qrw[i].size() != 0), 32'd1);
          if (qrw[i].size() != 0) begin
            e = qrw[i].pop_front();
            chk("spcdt", i, dt[i], e.d);
            chk("strobe_gap", i, cnt[i], 32'(e.gap));
            chk("rom_reqs_done", i, 32'(qad[i].size()), 32'd0);
          end
          cnt[i]  = 0;
          last[i] = dt[i];
        end else begin
          chk("spcdt_hold", i, dt[i], last[i]);
        end
      end
      prev_rst[i] = rst[i];
    end
  end

  task automatic push_row(input int i, input logic [15:0] a0, input int n,
                          input logic [31:0] d, input int gap);
    for (int k = 0; k < n; k++) qad[i].push_back(a0 + 16'(k));
    qrw[i].push_back({8'(gap), d});
  endtask

  task automatic wait_strobe(input int i);
    for (int c = 0; c < 40; c++) begin
      @(negedge VCLKx4);
      #2;
      if (ft[i]) return;
    end
    timeouts++;
    $display("FAIL strobe_timeout[u%0d] got no SPCFT want one within 40 cycles", i);
  endtask

  task automatic release_rst(input int i);
    @(posedge VCLKx4);
    #2;
    rst[i] = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge VCLKx4);

    // Cached instance: miss, hit, misses, half toggle, wait states.
    spcad[0] = 13'h0005;
    push_row(0, 16'h0014, 4, 32'h44332211, 6);
    release_rst(0);
    wait_strobe(0);
    push_row(0, 16'h0014, 0, 32'h44332211, 2);
    wait_strobe(0);
    spcad[0] = 13'h1A08;
    push_row(0, 16'h6820, 4, 32'h11101312, 6);
    wait_strobe(0);
    spcad[0] = 13'h1A18;
    push_row(0, 16'h6860, 4, 32'h51505352, 6);
    wait_strobe(0);
    push_row(0, 16'h6860, 0, 32'h51505352, 2);
    wait_strobe(0);
    spcad[0]        = 13'h0005;
    stall_cycles[0] = 3;
    push_row(0, 16'h0014, 4, 32'h44332211, 9);
    wait_strobe(0);
    stall_cycles[0] = 0;
    spcad[0]        = 13'h1A08;
    push_row(0, 16'h6820, 4, 32'h11101312, 6);

    // Reset once byte 2 has been acknowledged, mid-cycle.
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge VCLKx4);
      #2;
      if (rq[0] && ak[0]) n++;
    end
    if (n < 3) begin
      timeouts++;
      $display("FAIL ack_timeout[u0] got %0d acks want 3", n);
    end
    @(posedge VCLKx4);
    #2;
    rst[0] = 1'b1;
    repeat (3) @(negedge VCLKx4);
    push_row(0, 16'h6820, 4, 32'h11101312, 6);
    release_rst(0);
    wait_strobe(0);
    rst[0] = 1'b1;

    // Uncached instance: same address twice fetches twice.
    spcad[1] = 13'h0005;
    push_row(1, 16'h0014, 4, 32'h44332211, 6);
    release_rst(1);
    wait_strobe(1);
    push_row(1, 16'h0014, 4, 32'h44332211, 6);
    wait_strobe(1);
    rst[1] = 1'b1;

    // Base 0xFFFE: address wraps through 0x0000.
    spcad[2] = 13'h0000;
    push_row(2, 16'hFFFE, 4, 32'h5B5A5A5B, 6);
    release_rst(2);
    wait_strobe(2);
    rst[2] = 1'b1;

    repeat (3) @(negedge VCLKx4);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total + timeouts);
    $finish;
  end

endmodule
